// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: input synchronisers, ps2_clk glitch filter, 11-bit
// frame FSM with watchdog, E0/F0 prefix folding and a first-word-fall-through
// output FIFO.
//
// Ports:
//   clk_i, rst_i      system clock, synchronous active-high reset
//   ps2_clk_i         raw PS/2 clock (asynchronous)
//   ps2_data_i        raw PS/2 data (asynchronous)
//   rd_en_i           pop the FIFO head (ignored when empty)
//   ovf_clr_i         clear overflow_o and err_cnt_o
//   rd_code_o         scan code at the FIFO head
//   rd_ext_o          head entry was preceded by E0
//   rd_brk_o          head entry was preceded by F0 (release)
//   empty_o, count_o  FIFO status
//   overflow_o        sticky: an event was dropped on a full FIFO
//   err_cnt_o         saturating count of discarded frames
module ps2_kbd_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILT_LEN   = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    input  logic                          rd_en_i,
    input  logic                          ovf_clr_i,
    output logic [7:0]                    rd_code_o,
    output logic                          rd_ext_o,
    output logic                          rd_brk_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o,
    output logic [7:0]                    err_cnt_o
);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCW = $clog2(FILT_LEN + 1);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    localparam logic [FCW-1:0] FiltMax = FCW'(FILT_LEN);
    localparam logic [WDW-1:0] WdMax   = WDW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Synchronisers and glitch filter
    logic           ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           strobe;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (ps2c_s2_q != filt_q) begin
            // Count consecutive cycles the synchronised level differs.
            if (filt_cnt_q == FiltMax - 1'b1) filt_d = ps2c_s2_q;
            else                              filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    assign strobe = filt_q & ~filt_d;

    // Frame FSM and watchdog
    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           frame_ok, frame_err, timeout;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        wd_d      = '0;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (strobe && !ps2d_s2_q) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            StData: begin
                if (strobe) begin
                    shift_d   = {ps2d_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (strobe) begin
                    par_d   = ps2d_s2_q;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (strobe) begin
                    state_d = StIdle;
                    if (ps2d_s2_q && (^{shift_q, par_q})) frame_ok  = 1'b1;
                    else                                  frame_err = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && !strobe) begin
            if (wd_q == WdMax - 1'b1) begin
                timeout = 1'b1;
                state_d = StIdle;
                shift_d = '0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    // Decoder, FIFO control and status
    logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    head;
    logic          push, do_push, do_pop, full, empty;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push    = frame_ok && (shift_q != 8'hE0) && (shift_q != 8'hF0);
    assign do_pop  = rd_en_i && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (frame_ok) begin
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
        if (frame_err || timeout) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
        end
        if (push && full && !do_pop) overflow_d = 1'b1;
        if (ovf_clr_i) begin
            overflow_d = 1'b0;
            err_cnt_d  = '0;
        end
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= {ext_pend_q, brk_pend_q, shift_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ps2c_s1_q  <= 1'b1;
            ps2c_s2_q  <= 1'b1;
            ps2d_s1_q  <= 1'b1;
            ps2d_s2_q  <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wd_q       <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            ps2c_s1_q  <= ps2_clk_i;
            ps2c_s2_q  <= ps2c_s1_q;
            ps2d_s1_q  <= ps2_data_i;
            ps2d_s2_q  <= ps2d_s1_q;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            wd_q       <= wd_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Outputs read as zero while empty so reset values hold without clearing memory.
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_code_o  = empty ? 8'h00 : head[7:0];
    assign rd_brk_o   = empty ? 1'b0 : head[8];
    assign rd_ext_o   = empty ? 1'b0 : head[9];
    assign empty_o    = empty;
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign overflow_o = overflow_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed self-checking bench for ps2_kbd_rx (FIFO_DEPTH=4, short TIMEOUT).
module tb_ps2_kbd_rx;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FILT_LEN   = 4;
    localparam int unsigned TIMEOUT    = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] rd_code;
    logic       rd_ext, rd_brk, empty, overflow;
    logic [2:0] count;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ps2_kbd_rx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FILT_LEN   (FILT_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .rd_en_i    (rd_en),
        .ovf_clr_i  (ovf_clr),
        .rd_code_o  (rd_code),
        .rd_ext_o   (rd_ext),
        .rd_brk_o   (rd_brk),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame bits LSB first: start, 8 data, odd parity, stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip_par,
                                             input logic stop);
        return {stop, (~^b) ^ flip_par, b, 1'b0};
    endfunction

    // Send the first nbits of a frame; after bit glitch_bit, pulse ps2_clk low briefly.
    task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            cycles(10);
            ps2_clk = 1'b0;
            cycles(20);
            ps2_clk = 1'b1;
            if (i == glitch_bit) begin
                cycles(5);
                ps2_clk = 1'b0;
                cycles(FILT_LEN - 1);
                ps2_clk = 1'b1;
            end
            cycles(10);
        end
        ps2_data = 1'b1;
        cycles(20);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0, 1'b1), 11, -1);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_status();
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        cycles(2);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_code", rd_code, 0);
        check("rst_ovf", overflow, 0);
        check("rst_err", err_cnt, 0);

        // Make code 1C
        send_byte(8'h1C);
        check("mk_count", count, 1);
        check("mk_head", {rd_ext, rd_brk, rd_code}, {2'b00, 8'h1C});
        check("mk_err", err_cnt, 0);
        pop();
        check("mk_pop_empty", empty, 1);

        // Extended break E0 F0 75 folds into one entry
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("ext_count", count, 1);
        check("ext_head", {rd_ext, rd_brk, rd_code}, {2'b11, 8'h75});
        pop();

        // Parity error then a good frame
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11, -1);
        send_byte(8'h32);
        check("par_err", err_cnt, 1);
        check("par_count", count, 1);
        check("par_head", {rd_ext, rd_brk, rd_code}, {2'b00, 8'h32});
        pop();
        clear_status();
        check("par_clr", err_cnt, 0);

        // Stop-bit error
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11, -1);
        check("stop_err", err_cnt, 1);
        check("stop_empty", empty, 1);
        clear_status();

        // Overflow on a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        check("ovf_count", count, 4);
        check("ovf_flag", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_head%0d", i), rd_code, i);
            pop();
        end
        check("ovf_drained", empty, 1);
        clear_status();
        check("ovf_clr", overflow, 0);

        // Watchdog abort after start + 4 data bits
        send_bits(mk_frame(8'h2A, 1'b0, 1'b1), 5, -1);
        cycles(TIMEOUT + 50);
        check("wd_err", err_cnt, 1);
        check("wd_empty", empty, 1);
        send_byte(8'h2A);
        check("wd_next_head", rd_code, 8'h2A);
        check("wd_next_count", count, 1);
        pop();
        clear_status();

        // Short glitch on ps2_clk mid-frame is filtered out
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 4);
        check("gl_count", count, 1);
        check("gl_head", {rd_ext, rd_brk, rd_code}, {2'b00, 8'h1C});
        check("gl_err", err_cnt, 0);
        pop();

        // Reset mid-frame
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11, -1);
        send_byte(8'hE0);
        send_byte(8'h1C);
        send_bits(mk_frame(8'h55, 1'b0, 1'b1), 5, -1);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(2);
        check("mr_empty", empty, 1);
        check("mr_count", count, 0);
        check("mr_err", err_cnt, 0);
        check("mr_code", {rd_ext, rd_brk, rd_code}, 0);
        check("mr_ovf", overflow, 0);
        send_byte(8'h1C);
        check("mr_head", {rd_ext, rd_brk, rd_code}, {2'b00, 8'h1C});
        check("mr_next_err", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule
